// File: rtl/mips_alu_muldiv.sv
// Registered MIPS ALU with an iterative multiply/divide unit and HI/LO registers.
// Every op is captured into an issue register, then executed the next cycle (single-cycle ops) or by the FSM.
module mips_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LOAD = (SHW + 1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_MFHI = 4'd13;
  localparam logic [3:0] OP_MFLO = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state, state_next;

  // Handshake: start is taken on a rising edge only while busy is low; busy covers the
  // issue cycle of a mul/div plus its RUN cycles, so at most one mul/div is ever in flight.
  logic             cap_valid;
  logic [3:0]       cap_op;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic             accept, cap_md, cap_single, cap_div, cap_signed, cap_b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] dvsr, hi_r, lo_r, raw_a;
  logic             md_div, neg_q, neg_r, div_zero;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_ovf;

  // Codes 8..11 (MULT/MULTU/DIV/DIVU) share the 10xx pattern; bit 1 picks divide, bit 0 unsigned.
  assign cap_md     = cap_valid && (cap_op[3:2] == 2'b10);
  assign cap_single = cap_valid && (cap_op[3:2] != 2'b10);
  assign cap_div    = cap_op[1];
  assign cap_signed = !cap_op[0];
  assign cap_b_zero = (cap_b == '0);

  assign busy      = cap_md || (state == S_RUN);
  assign accept    = start && !busy;
  assign Zero      = (ALUOut == '0);
  assign dbg_state = state;

  assign mag_a = (cap_signed && cap_a[WIDTH-1]) ? -cap_a : cap_a;
  assign mag_b = (cap_signed && cap_b[WIDTH-1]) ? -cap_b : cap_b;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cap_valid <= 1'b0;
      cap_op    <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
    end else begin
      cap_valid <= accept;
      if (accept) begin
        cap_op <= ALUCtl;
        cap_a  <= A;
        cap_b  <= B;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cap_md) state_next = (cap_div && cap_b_zero) ? S_FIN : S_RUN;
      S_RUN:   if (cnt == CNT_ONE) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // hi_r:lo_r is the shared product / remainder:quotient register pair; dvsr holds
  // the multiplicand or the divisor magnitude.
  assign mul_sum   = {1'b0, hi_r} + {1'b0, dvsr};
  assign div_shift = {hi_r, lo_r[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvsr};

  assign prod_fix = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
  assign quo_fix  = neg_q ? -lo_r : lo_r;
  assign rem_fix  = neg_r ? -hi_r : hi_r;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      dvsr     <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      raw_a    <= '0;
      md_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      DivZero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cap_md) begin
            cnt      <= CNT_LOAD;
            dvsr     <= mag_b;
            hi_r     <= '0;
            lo_r     <= mag_a;
            raw_a    <= cap_a;
            md_div   <= cap_div;
            neg_q    <= cap_signed && (cap_a[WIDTH-1] ^ cap_b[WIDTH-1]);
            neg_r    <= cap_signed && cap_a[WIDTH-1];
            div_zero <= cap_div && cap_b_zero;
            if (cap_div) DivZero <= 1'b0;
          end
        end
        S_RUN: begin
          cnt <= cnt - CNT_ONE;
          if (md_div) begin
            // Restoring step: keep the subtraction only when it did not borrow.
            if (!div_diff[WIDTH]) begin
              hi_r <= div_diff[WIDTH-1:0];
              lo_r <= {lo_r[WIDTH-2:0], 1'b1};
            end else begin
              hi_r <= div_shift[WIDTH-1:0];
              lo_r <= {lo_r[WIDTH-2:0], 1'b0};
            end
          end else if (lo_r[0]) begin
            {hi_r, lo_r} <= {mul_sum, lo_r[WIDTH-1:1]};
          end else begin
            {hi_r, lo_r} <= {1'b0, hi_r, lo_r[WIDTH-1:1]};
          end
        end
        S_FIN: begin
          if (div_zero) begin
            HI      <= raw_a;
            LO      <= '1;
            DivZero <= 1'b1;
          end else if (md_div) begin
            HI <= rem_fix;
            LO <= quo_fix;
          end else begin
            {HI, LO} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = cap_a + cap_b;
    diff    = cap_a - cap_b;
    case (cap_op)
      OP_AND:  alu_res = cap_a & cap_b;
      OP_OR:   alu_res = cap_a | cap_b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (cap_a[WIDTH-1] == cap_b[WIDTH-1]) && (sum[WIDTH-1] != cap_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (cap_a[WIDTH-1] != cap_b[WIDTH-1]) && (diff[WIDTH-1] != cap_a[WIDTH-1]);
      end
      OP_NOR:  alu_res = ~(cap_a | cap_b);
      OP_SLT:  alu_res = WIDTH'($signed(cap_a) < $signed(cap_b));
      OP_SLTU: alu_res = WIDTH'(cap_a < cap_b);
      OP_SLL:  alu_res = cap_a << cap_b[SHW-1:0];
      OP_SRL:  alu_res = cap_a >> cap_b[SHW-1:0];
      OP_MFHI: alu_res = HI;
      OP_MFLO: alu_res = LO;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ALUOut   <= '0;
      Overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= cap_single || (state == S_FIN);
      if (cap_single) begin
        ALUOut   <= alu_res;
        Overflow <= alu_ovf;
      end
    end
  end

endmodule
